ser_shift: RTL and testbench

SER_SHIFT -- requirements
Module: ser_shift

---
 rtl/ser_pkg.sv | 13 +
 rtl/ser_shift_if.sv | 14 +
 rtl/ser_shift.sv | 139 +++++++++++++
 tb/tb_ser_shift.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and parameter defaults for the serial shifter
package ser_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_HOLD_TK = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/ser_shift_if.sv
// rtl/ser_shift_if.sv - word-side transmit/receive bundle of the serial shifter
interface ser_shift_if #(
    parameter int DATA_W = ser_pkg::DEF_DATA_W
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              abort;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport master (output data, valid, abort, input ready, rx_data, rx_valid);
    modport slave  (input data, valid, abort, output ready, rx_data, rx_valid);
endinterface

// File: rtl/ser_shift.sv
// rtl/ser_shift.sv - mode-0 serial shifter paced by external rise/fall ticks
module ser_shift
    import ser_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int HOLD_TK = DEF_HOLD_TK
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              tk_rise_i,
    input  logic              tk_fall_i,
    output logic              tk_en_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              abort_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              sck_o,
    output logic              sdo_o,
    input  logic              sdi_i,
    output logic              cs_n_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int HC_W  = $clog2(HOLD_TK + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [HC_W-1:0]  HOLD_END = HC_W'(HOLD_TK);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic              sck_q, sck_d;
    logic              cs_n_q, cs_n_d;
    logic              tk_en_q, tk_en_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        tk_en_d    = tk_en_q;
        data_d     = data_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_i && !abort_i) begin
                    tx_d       = data_i;
                    bit_cnt_d  = '0;
                    hold_cnt_d = '0;
                    sck_d      = 1'b0;
                    cs_n_d     = 1'b0;
                    tk_en_d    = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_i) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    sck_d   = 1'b0;
                    tk_en_d = 1'b0;
                end else if (tk_rise_i) begin
                    // rise wins when both ticks land together
                    sck_d = 1'b1;
                    rx_d  = {rx_q[DATA_W-2:0], sdi_i};
                end else if (tk_fall_i) begin
                    sck_d     = 1'b0;
                    tx_d      = {tx_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end
            HOLD: begin
                if (abort_i) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    sck_d   = 1'b0;
                    tk_en_d = 1'b0;
                end else if (hold_cnt_q == HOLD_END) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    tk_en_d = 1'b0;
                    data_d  = rx_q;
                    valid_d = 1'b1;
                end else if (tk_rise_i) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            tk_en_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            tk_en_q    <= tk_en_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign sdo_o   = tx_q[DATA_W-1];
    assign tk_en_o = tk_en_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign sck_o   = sck_q;
    assign cs_n_o  = cs_n_q;

endmodule

// File: tb/tb_ser_shift.sv
// tb/tb_ser_shift.sv - self-checking bench for ser_shift
module tb_ser_shift;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_aux_n;
    logic inj_rise, inj_fall, both_inj;
    int   sdi_mode;
    int   checks = 0;
    int   errors = 0;

    ser_shift_if #(.DATA_W(8)) bus ();

    logic tk_rise, tk_fall, gen_en;
    logic tk_en, sck, sdo, sdi, cs_n;
    logic tk_en_h0, sck_h0, sdo_h0, cs_n_h0, ready_h0, vout_h0;
    logic tk_en_h3, sck_h3, sdo_h3, cs_n_h3, ready_h3, vout_h3;
    logic [7:0] rx_h0, rx_h3;
    logic [3:0] ph;

    // 100 MHz / 10 MHz ddfs model: rise mid-period, fall at period end
    assign gen_en = tk_en | tk_en_h0 | tk_en_h3;
    always @(posedge clk) begin
        if (!gen_en) ph <= 4'd0;
        else         ph <= (ph == 4'd9) ? 4'd0 : ph + 4'd1;
    end
    assign tk_rise = (gen_en && ph == 4'd4) | inj_rise;
    assign tk_fall = (gen_en && ph == 4'd9) | inj_fall | (both_inj && gen_en && ph == 4'd4);
    assign sdi = (sdi_mode == 0) ? sdo : (sdi_mode == 1) ? 1'b1 : ~sdo;

    ser_shift #(.DATA_W(8), .HOLD_TK(1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .tk_rise_i(tk_rise), .tk_fall_i(tk_fall), .tk_en_o(tk_en),
        .data_i(bus.data), .valid_i(bus.valid), .ready_o(bus.ready), .abort_i(bus.abort),
        .data_o(bus.rx_data), .valid_o(bus.rx_valid), .sck_o(sck), .sdo_o(sdo), .sdi_i(sdi), .cs_n_o(cs_n)
    );
    ser_shift #(.DATA_W(8), .HOLD_TK(0)) u_h0 (
        .clk_i(clk), .rst_n_i(rst_aux_n), .tk_rise_i(tk_rise), .tk_fall_i(tk_fall), .tk_en_o(tk_en_h0),
        .data_i(bus.data), .valid_i(bus.valid), .ready_o(ready_h0), .abort_i(bus.abort),
        .data_o(rx_h0), .valid_o(vout_h0), .sck_o(sck_h0), .sdo_o(sdo_h0), .sdi_i(sdo_h0), .cs_n_o(cs_n_h0)
    );
    ser_shift #(.DATA_W(8), .HOLD_TK(3)) u_h3 (
        .clk_i(clk), .rst_n_i(rst_aux_n), .tk_rise_i(tk_rise), .tk_fall_i(tk_fall), .tk_en_o(tk_en_h3),
        .data_i(bus.data), .valid_i(bus.valid), .ready_o(ready_h3), .abort_i(bus.abort),
        .data_o(rx_h3), .valid_o(vout_h3), .sck_o(sck_h3), .sdo_o(sdo_h3), .sdi_i(sdo_h3), .cs_n_o(cs_n_h3)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] d, input logic [7:0] exp_rx, input string tag);
        logic [7:0] sdo_bits;
        logic [7:0] got;
        logic       prev, done;
        int         npulse, guard;
        @(negedge clk);
        bus.data  = d;
        bus.valid = 1'b1;
        guard = 0;
        while (!bus.ready && guard < 200) begin @(negedge clk); guard++; end
        chk(bus.ready, 1, {tag, " ready before accept"});
        @(negedge clk);
        bus.valid = 1'b0;
        chk(cs_n, 0, {tag, " cs_n low after accept"});
        chk(tk_en, 1, {tag, " tk_en after accept"});
        chk(sdo, d[7], {tag, " sdo msb at cs fall"});
        npulse = 0; prev = 1'b0; done = 1'b0; sdo_bits = '0; got = '0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (sck && !prev) begin
                sdo_bits = {sdo_bits[6:0], sdo};
                npulse++;
            end
            prev = sck;
            if (bus.rx_valid) begin
                got  = bus.rx_data;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk(done, 1, {tag, " completion within budget"});
        chk(npulse, 8, {tag, " sck pulse count"});
        chk(sdo_bits, d, {tag, " sdo bit sequence"});
        chk(got, exp_rx, {tag, " data_o"});
        @(negedge clk);
        chk(bus.rx_valid, 0, {tag, " valid_o one cycle"});
        chk(bus.rx_data, exp_rx, {tag, " data_o stable"});
        chk(bus.ready, 1, {tag, " ready after done"});
        chk(cs_n, 1, {tag, " cs_n high after done"});
    endtask

    initial begin
        logic [7:0] d, e;
        int m, n, guard, nvo, gap, falls, rises_after;
        int last_fall, r1, r3, up_a, up_h0, up_h3;
        logic prev_cs, prev_sck, ready_bad;
        logic [7:0] got [2];

        rst_n = 1'b0; rst_aux_n = 1'b0;
        inj_rise = 1'b0; inj_fall = 1'b0; both_inj = 1'b0; sdi_mode = 0;
        bus.data = '0; bus.valid = 1'b0; bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk(bus.ready, 1, "reset ready");
        chk(tk_en, 0, "reset tk_en");
        chk(cs_n, 1, "reset cs_n");
        chk(sck, 0, "reset sck");
        chk(bus.rx_valid, 0, "reset valid_o");
        chk(bus.rx_data, 0, "reset data_o");
        rst_n = 1'b1;

        // stray ticks while idle must do nothing
        @(negedge clk); inj_rise = 1'b1;
        @(negedge clk); inj_rise = 1'b0; inj_fall = 1'b1;
        @(negedge clk); inj_fall = 1'b0;
        @(negedge clk);
        chk(sck, 0, "idle tick sck");
        chk(cs_n, 1, "idle tick cs_n");
        chk(bus.ready, 1, "idle tick ready");

        sdi_mode = 0; xfer(8'hA5, 8'hA5, "loop A5");
        sdi_mode = 1; xfer(8'h00, 8'hFF, "sdi1 00");

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            m = ($urandom_range(0, 1) == 1) ? 2 : 0;
            e = (m == 0) ? d : ~d;
            sdi_mode = m;
            xfer(d, e, $sformatf("rand%0d", i));
        end

        both_inj = 1'b1; sdi_mode = 0;
        d = 8'($urandom);
        xfer(d, d, "both ticks");
        both_inj = 1'b0;

        // abort one cycle after the third fall tick
        @(negedge clk); bus.data = 8'h96; bus.valid = 1'b1;
        @(negedge clk); bus.valid = 1'b0;
        n = 0; guard = 0;
        while (n < 3 && guard < 200) begin
            if (tk_fall && !cs_n) n++;
            @(negedge clk); guard++;
        end
        chk(n, 3, "abort reached third fall");
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk(cs_n, 1, "abort cs_n");
        chk(tk_en, 0, "abort tk_en");
        chk(sck, 0, "abort sck");
        chk(bus.ready, 1, "abort ready");
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.rx_valid) n++;
            @(negedge clk);
        end
        chk(n, 0, "abort no valid_o");

        // reset in the middle of a shift
        @(negedge clk); bus.data = 8'h5A; bus.valid = 1'b1;
        @(negedge clk); bus.valid = 1'b0;
        n = 0; guard = 0; prev_sck = 1'b0;
        while (n < 3 && guard < 200) begin
            if (sck && !prev_sck) n++;
            prev_sck = sck;
            @(negedge clk); guard++;
        end
        chk(n, 3, "midreset reached shift");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk(bus.ready, 1, "midreset ready");
        chk(tk_en, 0, "midreset tk_en");
        chk(cs_n, 1, "midreset cs_n");
        chk(sck, 0, "midreset sck");
        chk(bus.rx_valid, 0, "midreset valid_o");
        chk(bus.rx_data, 0, "midreset data_o");
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.rx_valid || !cs_n) n++;
            @(negedge clk);
        end
        chk(n, 0, "midreset quiet after release");
        sdi_mode = 0; xfer(8'h3C, 8'h3C, "after reset 3C");

        // two words with valid held high throughout
        @(negedge clk);
        bus.data = 8'h12; bus.valid = 1'b1;
        nvo = 0; gap = 0; falls = 0; prev_cs = 1'b1; ready_bad = 1'b0;
        got[0] = '0; got[1] = '0;
        for (int c = 0; c < 1000 && nvo < 2; c++) begin
            if (prev_cs && !cs_n) begin
                falls++;
                if (falls == 1) bus.data = 8'h34;
                else begin
                    bus.valid = 1'b0;
                    chk((gap >= 1), 1, "b2b cs_n high gap");
                end
            end
            if (falls == 1 && cs_n) gap++;
            if (!cs_n && bus.ready) ready_bad = 1'b1;
            if (bus.rx_valid) begin got[nvo] = bus.rx_data; nvo++; end
            prev_cs = cs_n;
            @(negedge clk);
        end
        bus.valid = 1'b0;
        chk(nvo, 2, "b2b two completions");
        chk(falls, 2, "b2b two transfers");
        chk(got[0], 8'h12, "b2b first word");
        chk(got[1], 8'h34, "b2b second word");
        chk(ready_bad, 0, "b2b ready low while busy");

        // cs_n release timing for HOLD_TK 0, 1 and 3 on a shared tick stream
        rst_n = 1'b0; rst_aux_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; rst_aux_n = 1'b1;
        @(negedge clk);
        chk({ready_h0, ready_h3, bus.ready}, 3'b111, "hold all ready");
        bus.data = 8'h81; bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        falls = 0; rises_after = 0; last_fall = -1; r1 = -1; r3 = -1;
        up_a = -1; up_h0 = -1; up_h3 = -1;
        for (int c = 0; c < 400 && (up_a < 0 || up_h0 < 0 || up_h3 < 0); c++) begin
            if (falls == 8 && tk_rise) begin
                rises_after++;
                if (rises_after == 1) r1 = c;
                if (rises_after == 3) r3 = c;
            end
            if (tk_fall && gen_en && falls < 8) begin
                falls++;
                if (falls == 8) last_fall = c;
            end
            if (cs_n && up_a < 0) up_a = c;
            if (cs_n_h0 && up_h0 < 0) up_h0 = c;
            if (cs_n_h3 && up_h3 < 0) up_h3 = c;
            @(negedge clk);
        end
        chk(falls, 8, "hold fall count");
        chk(up_h0, last_fall + 2, "hold0 cs_n rise cycle");
        chk(up_a, r1 + 2, "hold1 cs_n rise cycle");
        chk(up_h3, r3 + 2, "hold3 cs_n rise cycle");
        chk(rx_h0, 8'h81, "hold0 data_o");
        chk(rx_h3, 8'h81, "hold3 data_o");
        chk(bus.rx_data, 8'h81, "hold1 data_o");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
